fetch_unit: RTL

//  IF stage. Owns the PC, fetches from instruction memory over a req/gnt/rvalid handshake and computes the static prediction.

---
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage. Owns the PC, fetches over a req/gnt/rvalid handshake,
// registers instruction, PC, PC+4 and the static branch/JAL target to decode.
// Optional feature macro: BTFN_PREDICT_EN (backward-taken/forward-not-taken and
// JAL-taken prediction). Without it the next PC is always PC+4.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_4_out,
    output logic [31:0] pc_imm_out
);

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        drop;       // outstanding response belongs to a squashed request
    logic [31:0] buf_instr;  // response captured while decode was stalled

    logic [31:0] src_instr;
    logic        is_branch;
    logic        is_jal;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] next_pc;

    // Target and prediction for whichever instruction is about to be presented
    always_comb begin
        src_instr = (state == S_HOLD) ? buf_instr : imem_rdata;
        is_branch = (src_instr[6:0] == OP_BRANCH);
        is_jal    = (src_instr[6:0] == OP_JAL);
        imm_b     = {{20{src_instr[31]}}, src_instr[7], src_instr[30:25],
                     src_instr[11:8], 1'b0};
        imm_j     = {{12{src_instr[31]}}, src_instr[19:12], src_instr[20],
                     src_instr[30:21], 1'b0};
        pc_plus4  = pc + 32'd4;
        if (is_branch) begin
            target = pc + imm_b;
        end else if (is_jal) begin
            target = pc + imm_j;
        end else begin
            target = pc_plus4;
        end
`ifdef BTFN_PREDICT_EN
        if (is_jal || (is_branch && src_instr[31])) begin
            next_pc = target & 32'hFFFF_FFFC;
        end else begin
            next_pc = pc_plus4 & 32'hFFFF_FFFC;
        end
`else
        next_pc = pc_plus4 & 32'hFFFF_FFFC;
`endif
    end

    // Request is only offered in S_REQ and never while reset is held
    always_comb begin
        imem_req  = (state == S_REQ) && !reset;
        imem_addr = pc;
    end

    // Fetch FSM, PC and registered decoder-facing outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            buf_instr  <= NOP;
            instr_out  <= NOP;
            pc_out     <= 32'h0;
            pc_4_out   <= 32'h0;
            pc_imm_out <= 32'h0;
        end else begin
            // No new instruction this cycle means a bubble, unless decode holds us
            if (!stall) begin
                instr_out <= NOP;
            end
            if (redirect_valid) begin
                pc        <= redirect_pc & 32'hFFFF_FFFC;
                instr_out <= NOP;
                buf_instr <= NOP;
                case (state)
                    S_REQ: begin
                        if (imem_gnt) begin
                            state <= S_WAIT;
                            drop  <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            state <= S_REQ;
                            drop  <= 1'b0;
                        end else begin
                            drop  <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        state <= S_REQ;
                        drop  <= 1'b0;
                    end
                    default: begin
                        state <= S_REQ;
                        drop  <= 1'b0;
                    end
                endcase
            end else begin
                case (state)
                    S_REQ: begin
                        if (imem_gnt) begin
                            state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            if (drop) begin
                                drop  <= 1'b0;
                                state <= S_REQ;
                            end else if (stall) begin
                                buf_instr <= imem_rdata;
                                state     <= S_HOLD;
                            end else begin
                                instr_out  <= src_instr;
                                pc_out     <= pc;
                                pc_4_out   <= pc_plus4;
                                pc_imm_out <= target;
                                pc         <= next_pc;
                                state      <= S_REQ;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!stall) begin
                            instr_out  <= src_instr;
                            pc_out     <= pc;
                            pc_4_out   <= pc_plus4;
                            pc_imm_out <= target;
                            pc         <= next_pc;
                            buf_instr  <= NOP;
                            state      <= S_REQ;
                        end
                    end
                    default: begin
                        state <= S_REQ;
                    end
                endcase
            end
        end
    end

endmodule
